// File: rtl/multicycle_adder.sv
// ---------------------------------------------------------------------------
// multicycle_adder
//
// Sequential adder/subtractor. Adds SLICE bits per clock and passes the carry
// between slices through a flop, so only a SLICE-bit carry chain sits between
// registers. A full WIDTH-bit result appears N = WIDTH/SLICE clocks after
// i_Start is accepted. The result is held until i_Start is released.
//
// Ports:
//   i_Clk        clock, rising edge
//   i_Reset_n    asynchronous active-low reset
//   i_Start      level request, sampled only in IDLE
//   i_Sub        0 = add, 1 = subtract (sampled with i_Start)
//   i_Cin        carry-in for add, ignored for subtract
//   i_A, i_B     operands (sampled with i_Start)
//   o_S          registered WIDTH-bit result
//   o_Cout       carry out of the MSB (subtract: 1 = no borrow)
//   o_Overflow   signed overflow (carry into MSB xor carry out of MSB)
//   o_Busy       high while slices are being added
//   o_Done       high while the result is being presented
// ---------------------------------------------------------------------------
module multicycle_adder #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             i_Clk,
    input  logic             i_Reset_n,
    input  logic             i_Start,
    input  logic             i_Sub,
    input  logic             i_Cin,
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    output logic [WIDTH-1:0] o_S,
    output logic             o_Cout,
    output logic             o_Overflow,
    output logic             o_Busy,
    output logic             o_Done
);

    localparam int N    = WIDTH / SLICE;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    if ((SLICE < 1) || (WIDTH % SLICE != 0)) begin : g_badSlice
        $error("multicycle_adder: WIDTH (%0d) must be a positive multiple of SLICE (%0d)",
               WIDTH, SLICE);
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_opA;
    logic [WIDTH-1:0] r_opB;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [IDXW-1:0]  r_idx;

    logic [SLICE-1:0] w_sliceA;
    logic [SLICE-1:0] w_sliceB;
    logic [SLICE:0]   w_sliceSum;
    logic [WIDTH-1:0] w_nextSum;
    logic             w_carryIntoMsb;

    // The operand registers shift right by SLICE every RUN cycle, so the slice
    // being worked on always sits in the low bits. This is the same as
    // selecting slice r_idx of the latched operands, but needs no variable
    // part-selects and stays legal when SLICE equals WIDTH.
    assign w_sliceA   = r_opA[SLICE-1:0];
    assign w_sliceB   = r_opB[SLICE-1:0];
    assign w_sliceSum = {1'b0, w_sliceA} + {1'b0, w_sliceB} + {{SLICE{1'b0}}, r_carry};

    // Slice sums enter at the top of the sum register and move down, so after
    // N cycles slice 0 has reached bit 0.
    assign w_nextSum = (r_sum >> SLICE)
                     | (WIDTH'(w_sliceSum[SLICE-1:0]) << (WIDTH - SLICE));

    // Top sum bit = a ^ b ^ carry_in, so the carry into the MSB falls out of
    // the slice's own operand and sum bits. Only meaningful on the last slice.
    assign w_carryIntoMsb = w_sliceSum[SLICE-1] ^ w_sliceA[SLICE-1] ^ w_sliceB[SLICE-1];

    // Control FSM and datapath registers. Subtract is done as A + ~B + 1.
    // Results are copied to the outputs only on the final slice, so the
    // previous result stays visible while a new operation runs.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_state    <= IDLE;
            r_opA      <= '0;
            r_opB      <= '0;
            r_sum      <= '0;
            r_carry    <= 1'b0;
            r_idx      <= '0;
            o_S        <= '0;
            o_Cout     <= 1'b0;
            o_Overflow <= 1'b0;
            o_Busy     <= 1'b0;
            o_Done     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_Start) begin
                        r_opA   <= i_A;
                        r_opB   <= i_Sub ? ~i_B : i_B;
                        r_carry <= i_Sub ? 1'b1 : i_Cin;
                        r_idx   <= '0;
                        r_sum   <= '0;
                        o_Busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end

                RUN: begin
                    r_opA   <= r_opA >> SLICE;
                    r_opB   <= r_opB >> SLICE;
                    r_sum   <= w_nextSum;
                    r_carry <= w_sliceSum[SLICE];
                    r_idx   <= r_idx + IDXW'(1);
                    if (r_idx == IDXW'(N - 1)) begin
                        o_S        <= w_nextSum;
                        o_Cout     <= w_sliceSum[SLICE];
                        o_Overflow <= w_carryIntoMsb ^ w_sliceSum[SLICE];
                        o_Busy     <= 1'b0;
                        o_Done     <= 1'b1;
                        r_state    <= DONE;
                    end
                end

                DONE: begin
                    // Start must drop before another operation can begin.
                    if (!i_Start) begin
                        o_Done  <= 1'b0;
                        r_state <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_adder.sv
// ---------------------------------------------------------------------------
// tb_multicycle_adder
//
// Drives three multicycle_adder instances (SLICE = 4, 1, 16) from the same
// inputs. A behavioural model predicts result, Busy and Done for each
// instance, and a compare process checks every instance each cycle. Directed
// vectors add literal expectations on top.
// ---------------------------------------------------------------------------
module tb_multicycle_adder;

    localparam int WIDTH = 16;
    localparam int NS [3] = '{4, 16, 1};

    logic clk = 1'b0;
    logic rstN;
    logic tStart;
    logic tSub;
    logic tCin;
    logic [WIDTH-1:0] tA;
    logic [WIDTH-1:0] tB;

    logic [WIDTH-1:0] dS    [3];
    logic             dCout [3];
    logic             dOvf  [3];
    logic             dBusy [3];
    logic             dDone [3];

    int nChecks = 0;
    int nPass   = 0;
    logic checkEn = 1'b0;

    // Clock generation.
    always #5 clk = ~clk;

    multicycle_adder #(.WIDTH(WIDTH), .SLICE(4)) u_slice4 (
        .i_Clk(clk), .i_Reset_n(rstN), .i_Start(tStart), .i_Sub(tSub), .i_Cin(tCin),
        .i_A(tA), .i_B(tB), .o_S(dS[0]), .o_Cout(dCout[0]), .o_Overflow(dOvf[0]),
        .o_Busy(dBusy[0]), .o_Done(dDone[0]));

    multicycle_adder #(.WIDTH(WIDTH), .SLICE(1)) u_slice1 (
        .i_Clk(clk), .i_Reset_n(rstN), .i_Start(tStart), .i_Sub(tSub), .i_Cin(tCin),
        .i_A(tA), .i_B(tB), .o_S(dS[1]), .o_Cout(dCout[1]), .o_Overflow(dOvf[1]),
        .o_Busy(dBusy[1]), .o_Done(dDone[1]));

    multicycle_adder #(.WIDTH(WIDTH), .SLICE(16)) u_slice16 (
        .i_Clk(clk), .i_Reset_n(rstN), .i_Start(tStart), .i_Sub(tSub), .i_Cin(tCin),
        .i_A(tA), .i_B(tB), .o_S(dS[2]), .o_Cout(dCout[2]), .o_Overflow(dOvf[2]),
        .o_Busy(dBusy[2]), .o_Done(dDone[2]));

    // Shared comparison helper: counts every check and reports mismatches.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic from integer math: {S, Cout, Overflow}.
    function automatic logic [17:0] refCalc(input logic [15:0] a, input logic [15:0] b,
                                            input logic sub, input logic cin);
        int u;
        int sv;
        logic [15:0] s;
        logic c;
        logic v;
        if (!sub) begin
            u  = int'(a) + int'(b) + int'(cin);
            sv = int'($signed(a)) + int'($signed(b)) + int'(cin);
            c  = (u > 65535);
        end else begin
            u  = int'(a) - int'(b);
            sv = int'($signed(a)) - int'($signed(b));
            c  = (a >= b);
        end
        s = u[15:0];
        v = (sv > 32767) || (sv < -32768);
        return {s, c, v};
    endfunction

    // Behavioural model: an accepted request yields its result N clocks later,
    // Busy covers those N clocks, and Done holds until Start is low.
    logic [17:0] mRes  [3] = '{default: '0};
    logic [17:0] mPend [3] = '{default: '0};
    logic        mBusy [3] = '{default: 1'b0};
    logic        mDone [3] = '{default: 1'b0};
    int          mCnt  [3] = '{default: 0};

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int d = 0; d < 3; d++) begin
                mRes[d]  <= '0;
                mPend[d] <= '0;
                mBusy[d] <= 1'b0;
                mDone[d] <= 1'b0;
                mCnt[d]  <= 0;
            end
        end else begin
            for (int d = 0; d < 3; d++) begin
                if (mBusy[d]) begin
                    if (mCnt[d] == 1) begin
                        mBusy[d] <= 1'b0;
                        mDone[d] <= 1'b1;
                        mRes[d]  <= mPend[d];
                    end
                    mCnt[d] <= mCnt[d] - 1;
                end else if (mDone[d]) begin
                    if (!tStart) mDone[d] <= 1'b0;
                end else if (tStart) begin
                    mPend[d] <= refCalc(tA, tB, tSub, tCin);
                    mBusy[d] <= 1'b1;
                    mCnt[d]  <= NS[d];
                end
            end
        end
    end

    // Cycle-by-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        if (checkEn) begin
            for (int d = 0; d < 3; d++) begin
                checkOutput($sformatf("S[%0d]", d),    32'(dS[d]),    32'(mRes[d][17:2]));
                checkOutput($sformatf("Cout[%0d]", d), 32'(dCout[d]), 32'(mRes[d][1]));
                checkOutput($sformatf("Ovf[%0d]", d),  32'(dOvf[d]),  32'(mRes[d][0]));
                checkOutput($sformatf("Busy[%0d]", d), 32'(dBusy[d]), 32'(mBusy[d]));
                checkOutput($sformatf("Done[%0d]", d), 32'(dDone[d]), 32'(mDone[d]));
            end
        end
    end

    // Waits (bounded) until every instance reports Done.
    task automatic waitAllDone(input int bound);
        int i;
        i = 0;
        while (!(dDone[0] && dDone[1] && dDone[2]) && (i < bound)) begin
            @(negedge clk);
            i++;
        end
        if (!(dDone[0] && dDone[1] && dDone[2])) begin
            checkOutput("doneTimeout", 32'd0, 32'd1);
        end
    endtask

    // Literal check of all outputs of one instance.
    task automatic checkLiteral(input int d, input logic [15:0] eS, input logic eC, input logic eV);
        checkOutput($sformatf("litS[%0d]", d),    32'(dS[d]),    32'(eS));
        checkOutput($sformatf("litCout[%0d]", d), 32'(dCout[d]), 32'(eC));
        checkOutput($sformatf("litOvf[%0d]", d),  32'(dOvf[d]),  32'(eV));
    endtask

    // Runs one operation on all instances, holds Start through Done for a few
    // clocks, then releases it and confirms the return to idle.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic sub,
                                 input logic cin, input logic [15:0] eS, input logic eC,
                                 input logic eV);
        tA = a; tB = b; tSub = sub; tCin = cin; tStart = 1'b1;
        waitAllDone(40);
        for (int d = 0; d < 3; d++) checkLiteral(d, eS, eC, eV);
        @(negedge clk);
        @(negedge clk);
        #1 tStart = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checkOutput($sformatf("idleDone[%0d]", d), 32'(dDone[d]), 32'd0);
            checkOutput($sformatf("idleBusy[%0d]", d), 32'(dBusy[d]), 32'd0);
        end
        #1;
    endtask

    initial begin
        rstN = 1'b1; tStart = 1'b0; tSub = 1'b0; tCin = 1'b0; tA = '0; tB = '0;
        #2 rstN = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) checkLiteral(d, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        #1 rstN = 1'b1;
        checkEn = 1'b1;

        // Pin the reference arithmetic with hand-computed values.
        checkOutput("modelAdd", 32'(refCalc(16'h1234, 16'h4321, 1'b0, 1'b1)), 32'({16'h5556, 2'b00}));
        checkOutput("modelSub", 32'(refCalc(16'h8000, 16'h0001, 1'b1, 1'b0)), 32'({16'h7FFF, 2'b11}));

        $display("[TB] directed add/sub vectors");
        applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5556, 1'b0, 1'b0);
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        applyStimulus(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        applyStimulus(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);

        // Inputs change and Start pulses while the slow instances are running.
        // The single-slice instance finishes first, drops to idle on the low
        // pulse and then runs the perturbed operation.
        $display("[TB] input changes during RUN");
        tA = 16'h1234; tB = 16'h4321; tSub = 1'b0; tCin = 1'b1; tStart = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1 tA = 16'hAAAA; tB = 16'h5555; tSub = 1'b1; tStart = 1'b0;
        @(negedge clk);
        #1 tStart = 1'b1;
        waitAllDone(40);
        checkLiteral(0, 16'h5556, 1'b0, 1'b0);
        checkLiteral(1, 16'h5556, 1'b0, 1'b0);
        checkLiteral(2, 16'h5555, 1'b1, 1'b1);
        #1 tStart = 1'b0;
        @(negedge clk);
        #1;

        // Reset on the second RUN cycle of the 4-slice instance, Start high.
        $display("[TB] reset during RUN");
        tA = 16'hFFFF; tB = 16'h0001; tSub = 1'b0; tCin = 1'b0; tStart = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1 rstN = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            checkLiteral(d, 16'h0000, 1'b0, 1'b0);
            checkOutput($sformatf("rstBusy[%0d]", d), 32'(dBusy[d]), 32'd0);
            checkOutput($sformatf("rstDone[%0d]", d), 32'(dDone[d]), 32'd0);
        end
        tStart = 1'b0;
        @(negedge clk);
        #1 rstN = 1'b1;
        applyStimulus(16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

        @(negedge clk);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/multicycle_adder.md
Name: multicycle_adder

Overview:
- Parametrised, sequential adder/subtractor. Computes a WIDTH-bit sum SLICE bits per clock, rippling the carry through a registered carry flop between slices.
- Trades latency for a short combinational path. Serves datapaths that cannot close timing with a full-width ripple chain.
- Start/Done handshake, compatible with the team's Execute-style control FSMs: result held until Start is released.

Parameters:
- WIDTH, 16, operand and result width in bits.
- SLICE, 4, bits added per RUN cycle. WIDTH % SLICE must be 0; otherwise elaboration fails with $error.
- N = WIDTH/SLICE is derived, not a parameter: number of RUN cycles.

Ports:
- Clk  input  1  sole clock, rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Start  input  1  level request; sampled only in IDLE.
- Sub  input  1  0 = add, 1 = subtract; sampled with Start.
- Cin  input  1  carry-in for add; ignored when Sub=1.
- A  input  WIDTH  operand A; sampled with Start.
- B  input  WIDTH  operand B; sampled with Start.
- S  output  WIDTH  registered result.
- Cout  output  1  carry out of MSB; for subtract, 1 = no borrow.
- Overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB.
- Busy  output  1  high in RUN.
- Done  output  1  high in DONE.

Behaviour:
- Reset (Reset_n=0, asynchronous): state=IDLE; S=0, Cout=0, Overflow=0, Busy=0, Done=0; internal operand regs, slice index and carry flop=0. Takes effect immediately, including mid-RUN. The partial result is discarded.
- States: IDLE, RUN, DONE.
- IDLE -> RUN on an edge with Start=1:
  - latch opA=A, opB = Sub ? ~B : B;
  - carry = Sub ? 1 : Cin;
  - index=0.
  - S/Cout/Overflow keep their previous values.
- RUN, each edge:
  - add slice [index*SLICE +: SLICE] of opA and opB plus carry;
  - write the slice sum into the internal sum reg; carry <= slice carry out; index++.
  - Start, A, B, Sub, Cin are ignored.
- Last slice (index=N-1):
  - S <= complete sum; Cout <= final carry;
  - Overflow <= carry into bit WIDTH-1 XOR final carry;
  - state <= DONE.
- Latency: Start sampled at edge k; S/Cout/Overflow valid and Done=1 after edge k+N; Busy=1 after edges k..k+N-1.
- DONE: outputs held stable. DONE -> IDLE on the first edge with Start=0. Start held high in DONE never retriggers; a new operation needs Start low for at least one edge.
- SLICE=WIDTH: N=1, single RUN cycle. SLICE=1: bit-serial.
- Arithmetic is modulo 2^WIDTH:
  - add: S = A+B+Cin;
  - sub: S = A-B (two's complement).

Test Plan:
- Reset: drive Reset_n=0 mid-simulation with Start=1 -> S=0x0000, Cout=0, Overflow=0, Busy=0, Done=0 immediately, without waiting for a clock edge.
- WIDTH=16, SLICE=4, add, A=0x1234, B=0x4321, Cin=1 -> S=0x5556, Cout=0, Overflow=0. Done rises exactly 4 edges after the Start edge; Busy high for exactly 4 cycles.
- Carry chain across all slices: A=0xFFFF, B=0x0001, Cin=0 -> S=0x0000, Cout=1, Overflow=0.
- Signed overflow on add: A=0x7FFF, B=0x0001, Cin=0 -> S=0x8000, Cout=0, Overflow=1.
- Subtract, each pair run as a separate operation:
  - Sub=1, A=0x0005, B=0x0007, Cin=1 (ignored) -> S=0xFFFE, Cout=0, Overflow=0;
  - A=0x8000, B=0x0001 -> S=0x7FFF, Cout=1, Overflow=1.
- Handshake and abort:
  - change A/B/Sub and pulse Start during RUN -> result unaffected;
  - hold Start high through DONE -> no second operation; release Start -> IDLE next edge;
  - assert Reset_n low on the 2nd RUN cycle -> IDLE, outputs 0, and a following clean operation is correct.
- Re-run the add vectors with SLICE=1 (Done after 16 edges) and SLICE=16 (Done after 1 edge) -> identical S/Cout/Overflow.
